// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate divider, horizontal/vertical counters and
// registered sync/active/coordinate outputs that lag the counters by one clk_in.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0
) (
  input  logic       clk_in,
  input  logic       i_rst,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_active,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_pix_en,
  output logic       o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  // 11-bit limits so a 1024-wide region still compares correctly against 10-bit counters
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic        SYNC_ON    = 1'(SYNC_POL);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;

  logic [DIV_W-1:0] w_div_nxt;
  logic [9:0]       w_h_nxt;
  logic [9:0]       w_v_nxt;
  logic [10:0]      w_h_ext;
  logic [10:0]      w_v_ext;
  logic             w_div_last;
  logic             w_h_act;
  logic             w_v_act;
  logic             w_hs_on;
  logic             w_vs_on;
  logic             w_fs;

  assign w_h_ext = {1'b0, r_h};
  assign w_v_ext = {1'b0, r_v};

  // Counter advance: div every clock, h on the last div phase, v on the h wrap
  always_comb begin
    w_div_last = (r_div == DIV_LAST);
    w_div_nxt  = r_div;
    w_h_nxt    = r_h;
    w_v_nxt    = r_v;
    if (w_div_last) begin
      w_div_nxt = DIV_ZERO;
      if (w_h_ext == H_LAST) begin
        w_h_nxt = 10'd0;
        if (w_v_ext == V_LAST) begin
          w_v_nxt = 10'd0;
        end else begin
          w_v_nxt = r_v + 10'd1;
        end
      end else begin
        w_h_nxt = r_h + 10'd1;
      end
    end else begin
      w_div_nxt = r_div + DIV_ONE;
    end
  end

  // Position decode of the current counter state
  always_comb begin
    w_h_act = (w_h_ext < H_ACT_END);
    w_v_act = (w_v_ext < V_ACT_END);
    w_hs_on = (w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END);
    w_vs_on = (w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END);
    w_fs    = (r_div == DIV_ZERO) && (r_h == 10'd0) && (r_v == 10'd0);
  end

  // Counter state registers
  always_ff @(posedge clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_div <= DIV_ZERO;
      r_h   <= 10'd0;
      r_v   <= 10'd0;
    end else begin
      r_div <= w_div_nxt;
      r_h   <= w_h_nxt;
      r_v   <= w_v_nxt;
    end
  end

  // Output registers carry the decode of the pre-edge state
  always_ff @(posedge clk_in or posedge i_rst) begin
    if (i_rst) begin
      o_hsync       <= ~SYNC_ON;
      o_vsync       <= ~SYNC_ON;
      o_active      <= 1'b0;
      o_x           <= 10'd0;
      o_y           <= 9'd0;
      o_pix_en      <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_hsync       <= w_hs_on ? SYNC_ON : ~SYNC_ON;
      o_vsync       <= w_vs_on ? SYNC_ON : ~SYNC_ON;
      o_active      <= w_h_act && w_v_act;
      o_x           <= w_h_act ? r_h : 10'd0;
      o_y           <= w_v_act ? r_v[8:0] : 9'd0;
      o_pix_en      <= w_div_last;
      o_frame_start <= w_fs;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three parameterisations compared every cycle against an
// arithmetic raster model, plus directed line/frame measurements and random async resets.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       pe;
    logic       fs;
    logic [9:0] x;
    logic [8:0] y;
  } vout_t;

  logic clk_in = 1'b0;
  logic i_rst  = 1'b1;
  int   n_edges = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  vout_t a_out, b_out, c_out;

  always #5 clk_in = ~clk_in;

  vga_sync_gen u_a (
    .clk_in(clk_in), .i_rst(i_rst),
    .o_hsync(a_out.hs), .o_vsync(a_out.vs), .o_active(a_out.act),
    .o_x(a_out.x), .o_y(a_out.y), .o_pix_en(a_out.pe), .o_frame_start(a_out.fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .SYNC_POL(1)
  ) u_b (
    .clk_in(clk_in), .i_rst(i_rst),
    .o_hsync(b_out.hs), .o_vsync(b_out.vs), .o_active(b_out.act),
    .o_x(b_out.x), .o_y(b_out.y), .o_pix_en(b_out.pe), .o_frame_start(b_out.fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .CLK_DIV(3), .SYNC_POL(0)
  ) u_c (
    .clk_in(clk_in), .i_rst(i_rst),
    .o_hsync(c_out.hs), .o_vsync(c_out.vs), .o_active(c_out.act),
    .o_x(c_out.x), .o_y(c_out.y), .o_pix_en(c_out.pe), .o_frame_start(c_out.fs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Expected outputs after s+1 edges since reset release, from plain raster arithmetic
  function automatic vout_t model(input bit in_rst, input int s,
                                  input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw, input int vb,
                                  input int dv, input int pol);
    vout_t r;
    int ht, vt, d, p, h, v;
    bit hs_on, vs_on;
    r = '0;
    if (in_rst) begin
      r.hs = (pol == 0);
      r.vs = (pol == 0);
      return r;
    end
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    d  = s % dv;
    p  = s / dv;
    h  = p % ht;
    v  = (p / ht) % vt;
    hs_on = (h >= ha + hf) && (h < ha + hf + hsw);
    vs_on = (v >= va + vf) && (v < va + vf + vsw);
    r.hs  = hs_on ? (pol != 0) : (pol == 0);
    r.vs  = vs_on ? (pol != 0) : (pol == 0);
    r.act = (h < ha) && (v < va);
    r.x   = (h < ha) ? 10'(h) : 10'd0;
    r.y   = (v < va) ? 9'(v) : 9'd0;
    r.pe  = (d == dv - 1);
    r.fs  = (d == 0) && (h == 0) && (v == 0);
    return r;
  endfunction

  task automatic cmp(input string name, input vout_t got, input vout_t exp);
    check({name, ".hsync"},  32'(got.hs),  32'(exp.hs));
    check({name, ".vsync"},  32'(got.vs),  32'(exp.vs));
    check({name, ".active"}, 32'(got.act), 32'(exp.act));
    check({name, ".x"},      32'(got.x),   32'(exp.x));
    check({name, ".y"},      32'(got.y),   32'(exp.y));
    check({name, ".pix_en"}, 32'(got.pe),  32'(exp.pe));
    check({name, ".fstart"}, 32'(got.fs),  32'(exp.fs));
  endtask

  always @(posedge clk_in) begin
    if (i_rst) n_edges <= 0;
    else       n_edges <= n_edges + 1;
  end

  always @(negedge clk_in) begin
    bit in_rst;
    in_rst = i_rst || (n_edges == 0);
    cmp("A", a_out, model(in_rst, n_edges - 1, 640, 16, 96, 48, 480, 10, 2, 33, 2, 0));
    cmp("B", b_out, model(in_rst, n_edges - 1, 4, 1, 1, 1, 3, 1, 1, 1, 1, 1));
    cmp("C", c_out, model(in_rst, n_edges - 1, 20, 3, 4, 5, 10, 2, 3, 2, 3, 0));
  end

  initial begin
    int act_cnt, hs_low, hs_fall, fs_cnt, vs_hi, hs_hi;
    repeat (3) @(posedge clk_in);
    #2 i_rst = 1'b0;

    // One default line: active, hsync position and width
    act_cnt = 0; hs_low = 0; hs_fall = -1;
    for (int i = 0; i < 1600; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (a_out.act) act_cnt++;
      if (!a_out.hs) begin
        hs_low++;
        if (hs_fall < 0) hs_fall = i;
      end
    end
    check("A.line_active_clks", 32'(act_cnt), 32'd1280);
    check("A.line_hsync_low",   32'(hs_low),  32'd192);
    check("A.line_hsync_fall",  32'(hs_fall), 32'd1312);

    // Random asynchronous resets mid-line
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(20, 3000)) @(posedge clk_in);
      #2 i_rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk_in);
      #2 i_rst = 1'b0;
    end

    // Ten small-format frames
    fs_cnt = 0; vs_hi = 0; hs_hi = 0;
    for (int i = 0; i < 420; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (b_out.fs) fs_cnt++;
      if (b_out.vs) vs_hi++;
      if (b_out.hs) hs_hi++;
    end
    check("B.frame_starts", 32'(fs_cnt), 32'd10);
    check("B.vsync_high",   32'(vs_hi),  32'd70);
    check("B.hsync_high",   32'(hs_hi),  32'd60);

    repeat (4000) @(posedge clk_in);
    @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
